// File: rtl/muldiv_pkg.sv
// rtl/muldiv_pkg.sv - shared op/state encodings and iteration count for the muldiv sequencer
package muldiv_pkg;

    localparam int MD_ITER = 32;

    typedef enum logic [1:0] {
        MD_MULT  = 2'b00,
        MD_MULTU = 2'b01,
        MD_DIV   = 2'b10,
        MD_DIVU  = 2'b11
    } md_op_e;

    typedef enum logic [1:0] {
        MD_IDLE = 2'b00,
        MD_RUN  = 2'b01,
        MD_FIX  = 2'b10
    } md_state_e;

endpackage

// File: rtl/muldiv_core.sv
// rtl/muldiv_core.sv - shift-add multiply / restoring divide datapath stepped by the sequencer
module muldiv_core #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             step,
    input  logic             is_div,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    output logic [WIDTH-1:0] acc,
    output logic [WIDTH-1:0] mq,
    output logic [WIDTH-1:0] b
);

    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   shl;
    logic             borrow;
    logic [WIDTH-1:0] rem_sub;

    // Multiply: conditional add keeps its carry so the right shift loses nothing.
    assign sum     = {1'b0, acc} + (mq[0] ? {1'b0, b} : '0);
    // Divide: remainder gets one extra bit after the left shift before the trial subtract.
    assign shl     = {acc, mq[WIDTH-1]};
    assign borrow  = shl < {1'b0, b};
    assign rem_sub = shl[WIDTH-1:0] - b;

    // Operand load on start, then one multiply or divide iteration per step.
    always_ff @(posedge clk) begin
        if (rst) begin
            acc <= '0;
            mq  <= '0;
            b   <= '0;
        end else if (load) begin
            acc <= '0;
            mq  <= a_in;
            b   <= b_in;
        end else if (step) begin
            if (is_div) begin
                acc <= borrow ? shl[WIDTH-1:0] : rem_sub;
                mq  <= {mq[WIDTH-2:0], ~borrow};
            end else begin
                acc <= sum[WIDTH:1];
                mq  <= {sum[0], mq[WIDTH-1:1]};
            end
        end
    end

endmodule

// File: rtl/muldiv_sequencer.sv
// rtl/muldiv_sequencer.sv - HI/LO multiply/divide sequencer; MULDIV_EARLY_TERM_EN enables multiply early exit
module muldiv_sequencer
    import muldiv_pkg::*;
#(
    parameter int WIDTH = MD_ITER,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] rs_val,
    input  logic [WIDTH-1:0] rt_val,
    input  logic             mthi,
    input  logic             mtlo,
    input  logic [WIDTH-1:0] wdata,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    md_state_e          state, state_next;
    logic [CNT_W-1:0]   cnt;
    logic               is_div_q, sign_a_q, sign_b_q;
    logic               signed_op, sign_a, sign_b, load, step;
    logic [WIDTH-1:0]   abs_rs, abs_rt, acc, mq, b;
    logic [2*WIDTH-1:0] prod_mag, prod;
    logic [WIDTH-1:0]   quot, rem, res_hi, res_lo;
    logic               dbz_hit, run_exit;

    assign signed_op = (op == MD_MULT) || (op == MD_DIV);
    assign sign_a    = signed_op & rs_val[WIDTH-1];
    assign sign_b    = signed_op & rt_val[WIDTH-1];
    assign abs_rs    = sign_a ? -rs_val : rs_val;
    assign abs_rt    = sign_b ? -rt_val : rt_val;
    assign load      = (state == MD_IDLE) && start;
    assign step      = (state == MD_RUN);

    // Multiplier rt goes in the shifting register; for divide the dividend rs does.
    muldiv_core #(.WIDTH(WIDTH)) u_core (
        .clk    (clk),
        .rst    (rst),
        .load   (load),
        .step   (step),
        .is_div (is_div_q),
        .a_in   (op[1] ? abs_rs : abs_rt),
        .b_in   (op[1] ? abs_rt : abs_rs),
        .acc    (acc),
        .mq     (mq),
        .b      (b)
    );

    // A multiply may stop once no unconsumed multiplier bits are set.
`ifdef MULDIV_EARLY_TERM_EN
    assign run_exit = (cnt == CNT_W'(1)) ||
                      (!is_div_q && (((mq >> 1) & ~({WIDTH{1'b1}} << (cnt - 1'b1))) == '0));
`else
    assign run_exit = (cnt == CNT_W'(1));
`endif

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) state <= MD_IDLE;
        else     state <= state_next;
    end

    // Next-state: IDLE -> RUN on start, RUN until the last iteration, FIX for one cycle.
    always_comb begin
        state_next = state;
        case (state)
            MD_IDLE: if (start) state_next = MD_RUN;
            MD_RUN:  if (run_exit) state_next = MD_FIX;
            MD_FIX:  state_next = MD_IDLE;
            default: state_next = MD_IDLE;
        endcase
    end

    // Iteration counter and the op/sign flags captured with start.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt      <= '0;
            is_div_q <= 1'b0;
            sign_a_q <= 1'b0;
            sign_b_q <= 1'b0;
        end else if (load) begin
            cnt      <= CNT_W'(WIDTH);
            is_div_q <= op[1];
            sign_a_q <= sign_a;
            sign_b_q <= sign_b;
        end else if (step) begin
            cnt      <= cnt - 1'b1;
        end
    end

    // Sign correction; remainder of a zero divisor is the dividend magnitude itself.
    always_comb begin
`ifdef MULDIV_EARLY_TERM_EN
        prod_mag = {acc, mq} >> cnt;
`else
        prod_mag = {acc, mq};
`endif
        prod    = (sign_a_q ^ sign_b_q) ? -prod_mag : prod_mag;
        quot    = (sign_a_q ^ sign_b_q) ? -mq : mq;
        rem     = sign_a_q ? -acc : acc;
        dbz_hit = is_div_q && (b == '0);
        res_hi  = is_div_q ? rem : prod[2*WIDTH-1:WIDTH];
        res_lo  = is_div_q ? (dbz_hit ? '1 : quot) : prod[WIDTH-1:0];
    end

    // HI/LO: result in FIX, MTHI/MTLO only while idle.
    always_ff @(posedge clk) begin
        if (rst) begin
            hi <= '0;
            lo <= '0;
        end else if (state == MD_FIX) begin
            hi <= res_hi;
            lo <= res_lo;
        end else if (state == MD_IDLE) begin
            if (mthi) hi <= wdata;
            if (mtlo) lo <= wdata;
        end
    end

    assign busy        = (state == MD_RUN) || (state == MD_FIX);
    assign done        = (state == MD_FIX);
    assign div_by_zero = done && dbz_hit;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// tb/tb_muldiv_sequencer.sv - scoreboard bench for muldiv_sequencer
module tb_muldiv_sequencer;
    import muldiv_pkg::*;

    logic        clk, rst, start, mthi, mtlo;
    logic [1:0]  op;
    logic [31:0] rs_val, rt_val, wdata, hi, lo;
    logic        busy, done, div_by_zero;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        logic        dbz;
        int          lat;
    } exp_t;

    exp_t sb[$];
    int   vectors = 0;
    int   miscompares = 0;
    int   cyc = 0;
    int   t_start = 0;

    muldiv_sequencer #(.WIDTH(32), .CNT_W(6)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .op          (op),
        .rs_val      (rs_val),
        .rt_val      (rt_val),
        .mthi        (mthi),
        .mtlo        (mtlo),
        .wdata       (wdata),
        .busy        (busy),
        .done        (done),
        .div_by_zero (div_by_zero),
        .hi          (hi),
        .lo          (lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [1:0] o, input logic [31:0] a, input logic [31:0] bv);
        start   = 1'b1;
        op      = o;
        rs_val  = a;
        rt_val  = bv;
        t_start = cyc;
        tick();
        start   = 1'b0;
        op      = o ^ 2'b01;
        rs_val  = 32'hDEAD_BEEF;
        rt_val  = 32'h0BAD_F00D;
    endtask

    task automatic collect(input string name);
        exp_t e;
        vectors++;
        if (busy !== 1'b1) begin
            miscompares++;
            $display("FAIL %s busy_running got %b want 1", name, busy);
        end
        while (done !== 1'b1 && (cyc - t_start) < 100) tick();
        e = sb.pop_front();
        vectors++;
        if (done !== 1'b1) begin
            miscompares++;
            $display("FAIL %s done_timeout got %b want 1", name, done);
        end else if (e.lat >= 0 && (cyc - t_start) != e.lat) begin
            miscompares++;
            $display("FAIL %s done_latency got %0d want %0d", name, cyc - t_start, e.lat);
        end
        vectors++;
        if (div_by_zero !== e.dbz) begin
            miscompares++;
            $display("FAIL %s div_by_zero got %b want %b", name, div_by_zero, e.dbz);
        end
        tick();
        vectors++;
        if (busy !== 1'b0) begin
            miscompares++;
            $display("FAIL %s busy_after got %b want 0", name, busy);
        end
        vectors++;
        if (hi !== e.hi) begin
            miscompares++;
            $display("FAIL %s hi got %h want %h", name, hi, e.hi);
        end
        vectors++;
        if (lo !== e.lo) begin
            miscompares++;
            $display("FAIL %s lo got %h want %h", name, lo, e.lo);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) tick();
        vectors++;
        if ({busy, done, div_by_zero} !== 3'b000) begin
            miscompares++;
            $display("FAIL reset_flags got %b want 000", {busy, done, div_by_zero});
        end
        vectors++;
        if (hi !== 32'h0 || lo !== 32'h0) begin
            miscompares++;
            $display("FAIL reset_hilo got %h/%h want 0/0", hi, lo);
        end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_mtx();
        mthi = 1'b1; mtlo = 1'b1; wdata = 32'hAAAA_5555;
        tick();
        mtlo = 1'b0; wdata = 32'h1357_9BDF;
        tick();
        mthi = 1'b0;
        vectors++;
        if (hi !== 32'h1357_9BDF || lo !== 32'hAAAA_5555) begin
            miscompares++;
            $display("FAIL mthi_mtlo got %h/%h want 13579bdf/aaaa5555", hi, lo);
        end
    endtask

    task automatic test_multu();
        sb.push_back('{32'hFFFF_FFFE, 32'h0000_0001, 1'b0, 33});
        issue(MD_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        collect("multu_max");
    endtask

    task automatic test_mult();
        sb.push_back('{32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0, -1});
        mthi = 1'b1; wdata = 32'h0000_1234;
        issue(MD_MULT, 32'hFFFF_FFFD, 32'd7);
        mthi = 1'b0;
        vectors++;
        if (hi !== 32'h0000_1234) begin
            miscompares++;
            $display("FAIL mthi_with_start got %h want 00001234", hi);
        end
        collect("mult_neg");
    endtask

    task automatic test_div();
        sb.push_back('{32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0, 33});
        issue(MD_DIV, 32'hFFFF_FFF9, 32'd2);
        collect("div_neg");
        sb.push_back('{32'h0, 32'h8000_0000, 1'b0, 33});
        issue(MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
        collect("div_overflow");
    endtask

    task automatic test_div_zero();
        sb.push_back('{32'h0000_0064, 32'hFFFF_FFFF, 1'b1, 33});
        issue(MD_DIVU, 32'd100, 32'd0);
        collect("divu_zero");
        sb.push_back('{32'hFFFF_FFF6, 32'hFFFF_FFFF, 1'b1, 33});
        issue(MD_DIV, 32'hFFFF_FFF6, 32'd0);
        collect("div_zero_signed");
    endtask

    task automatic test_ignored();
        int extra = 0;
        sb.push_back('{32'h0000_0001, 32'h8000_0003, 1'b0, 33});
        issue(MD_MULTU, 32'd3, 32'h8000_0001);
        repeat (4) tick();
        start = 1'b1; op = MD_DIVU; rs_val = 32'd9; rt_val = 32'd0;
        mthi = 1'b1; mtlo = 1'b1; wdata = 32'h0000_1234;
        tick();
        start = 1'b0; mthi = 1'b0; mtlo = 1'b0;
        collect("ignored_start");
        for (int i = 0; i < 40; i++) begin
            if (done === 1'b1) extra++;
            tick();
        end
        vectors++;
        if (extra != 0) begin
            miscompares++;
            $display("FAIL ignored_extra_done got %0d want 0", extra);
        end
    endtask

    task automatic test_reset_mid();
        int seen = 0;
        issue(MD_MULTU, 32'h1234_5678, 32'h8765_4321);
        while (cyc < t_start + 10) begin
            if (done === 1'b1) seen++;
            tick();
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        vectors++;
        if (busy !== 1'b0 || hi !== 32'h0 || lo !== 32'h0) begin
            miscompares++;
            $display("FAIL reset_mid got busy=%b hi=%h lo=%h want 0/0/0", busy, hi, lo);
        end
        for (int i = 0; i < 40; i++) begin
            if (done === 1'b1) seen++;
            tick();
        end
        vectors++;
        if (seen != 0) begin
            miscompares++;
            $display("FAIL reset_mid_done got %0d want 0", seen);
        end
    endtask

    task automatic test_early_term();
`ifdef MULDIV_EARLY_TERM_EN
        sb.push_back('{32'h0, 32'd15, 1'b0, 3});
`else
        sb.push_back('{32'h0, 32'd15, 1'b0, 33});
`endif
        issue(MD_MULTU, 32'd5, 32'd3);
        collect("early_term");
    endtask

    task automatic test_back_to_back();
        sb.push_back('{32'd6, 32'd142, 1'b0, 33});
        issue(MD_DIVU, 32'd1000, 32'd7);
        collect("b2b_divu");
        sb.push_back('{32'h0000_0001, 32'h0, 1'b0, -1});
        issue(MD_MULTU, 32'h0001_0000, 32'h0001_0000);
        collect("b2b_multu");
        sb.push_back('{32'hFFFF_FFFF, 32'hFFFF_FFF9, 1'b0, -1});
        issue(MD_MULT, 32'h0000_0007, 32'hFFFF_FFFF);
        collect("b2b_mult_neg1");
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; op = 2'b00; rs_val = '0; rt_val = '0;
        mthi = 1'b0; mtlo = 1'b0; wdata = '0;
        test_reset();
        test_mtx();
        test_multu();
        test_mult();
        test_div();
        test_div_zero();
        test_ignored();
        test_reset_mid();
        test_early_term();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/muldiv_sequencer.md
Name: muldiv_sequencer

Overview:
- Iterative multiply/divide unit with architectural HI/LO registers, sitting beside the ALU in the execute stage.
- Sequences 32-step shift-add multiply and restoring divide for MULT/MULTU/DIV/DIVU.
- Services MTHI/MTLO writes, and exposes HI/LO for MFHI/MFLO.
- Raises busy so the hazard logic stalls dependent instructions.

Parameters:
- WIDTH, 32, operand and HI/LO width.
- CNT_W, 6, iteration counter width; must hold WIDTH.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  synchronous active-high reset
- start  in  1  one-cycle request to begin an operation; sampled only in IDLE
- op  in  2  operation: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU
- rs_val  in  WIDTH  multiplicand / dividend
- rt_val  in  WIDTH  multiplier / divisor
- mthi  in  1  write wdata to HI
- mtlo  in  1  write wdata to LO
- wdata  in  WIDTH  MTHI/MTLO data
- busy  out  1  operation in progress
- done  out  1  one-cycle pulse when HI/LO are written with a result
- div_by_zero  out  1  pulses with done when a divide had rt_val==0
- hi  out  WIDTH  HI register
- lo  out  WIDTH  LO register

Behaviour:
- Clock and reset: one clock clk; reset rst is synchronous and active-high.
- Reset: state=IDLE; busy=0, done=0, div_by_zero=0, hi=0, lo=0, counter=0.
- Reset mid-operation aborts the operation: no done pulse, HI/LO cleared.
- FSM states: IDLE, RUN, FIX.
- IDLE: start=1 in cycle T latches absolute operands and sign flags (signed ops only), loads counter=WIDTH, then -> RUN.
- RUN: one iteration per cycle.
  - Multiply: if multiplier LSB is 1, add the multiplicand to the upper accumulator; shift the {acc, multiplier} pair right.
  - Divide: shift the {rem, quot} pair left, trial-subtract the divisor, set the quotient bit on no-borrow.
  - Decrement the counter; on counter==1 -> FIX.
- FIX: apply sign correction, write HI/LO, pulse done, then -> IDLE.
- Latency: start at T; busy=1 during T+1..T+33; done=1 at T+33; HI/LO hold the result from T+34; busy=0 at T+34.
- busy is combinational from state (RUN or FIX), so it is never high in IDLE.
- Signed multiply: the 64-bit magnitude product is negated when the operand signs differ. HI=upper 32 bits, LO=lower 32 bits.
- Signed divide: LO=quotient, negated when the signs differ; HI=remainder, carrying the sign of the dividend.
- 0x80000000 / 0xFFFFFFFF (signed) gives LO=0x80000000, HI=0.
- Divide by zero (signed or unsigned): HI=rs_val, LO=0xFFFFFFFF, div_by_zero=1 in the done cycle. Full latency still applies.
- start while busy is ignored; the hazard logic must stall the issuing instruction.
- mthi/mtlo while busy are ignored.
- mthi/mtlo in IDLE write at the next edge.
- mthi/mtlo in the same cycle as start: both are written, and the result overwrites them at FIX.
- mthi and mtlo together: both registers are written.
- op is sampled only with start; later changes have no effect.

Optional Feature:
- Macro: MULDIV_EARLY_TERM_EN.
- Defined: multiply leaves RUN for FIX after the first iteration whose remaining unshifted multiplier bits are all zero, with a minimum of 1 iteration. The accumulator is aligned by a final barrel shift in FIX. Divide is unaffected.
- Undefined: all operations take the full WIDTH iterations.

Decomposition:
- Package muldiv_pkg holds:
  - op encodings MD_MULT, MD_MULTU, MD_DIV, MD_DIVU;
  - FSM state encoding MD_IDLE, MD_RUN, MD_FIX;
  - constant MD_ITER = WIDTH.
- One sub-module is natural: muldiv_core, holding the accumulator/remainder shift registers and the adder/subtractor, stepped by enables from the sequencer FSM. HI/LO registers and the FSM stay in the top.

Test Plan:
- MULTU 0xFFFFFFFF*0xFFFFFFFF at T -> done at T+33; HI=0xFFFFFFFE, LO=0x00000001 at T+34; busy low at T+34.
- MULT -3*7 -> HI=0xFFFFFFFF, LO=0xFFFFFFEB.
- DIV -7/2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF.
- DIV 0x80000000/0xFFFFFFFF -> LO=0x80000000, HI=0.
- DIVU 100/0 -> HI=0x00000064, LO=0xFFFFFFFF, div_by_zero=1 coincident with done at T+33.
- Ignored requests and reset:
  - Second start and mthi(0x1234) during busy are ignored; HI equals the product.
  - rst at T+10 -> busy=0, hi=lo=0 at T+11, no done.
- Early termination:
  - Macro defined: MULTU 5*3 -> done at T+3, LO=15.
  - Macro undefined: same operation gives done at T+33.
